// File: rtl/seq_pkg.sv
// Shared types and default sizing for the sequence serializer and detector bench.
// SEQ_SER_PARITY_EN adds the PARITY state to ser_state_t.
package seq_pkg;

   localparam int unsigned DefWidth = 8;
   localparam int unsigned DefDepth = 4;

`ifdef SEQ_SER_PARITY_EN
   typedef enum logic [1:0] {StIdle, StShift, StParity} ser_state_t;
`else
   typedef enum logic [1:0] {StIdle, StShift} ser_state_t;
`endif

endpackage

// File: rtl/seq_sync_fifo.sv
// Small synchronous FIFO with registered occupancy count.
// Pushes when full and pops when empty are ignored.
module seq_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_push,
   input  logic [WIDTH-1:0]        i_data,
   input  logic                    i_pop,
   output logic [WIDTH-1:0]        o_data,
   output logic [$clog2(DEPTH):0]  o_count
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam logic [PtrW:0] Full = DEPTH[PtrW:0];

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PtrW-1:0]  r_wr_ptr;
   logic [PtrW-1:0]  r_rd_ptr;
   logic [PtrW:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign w_push  = i_push && (r_count < Full);
   assign w_pop   = i_pop && (r_count != '0);
   assign o_data  = r_mem[r_rd_ptr];
   assign o_count = r_count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      end
   end

   // Storage needs no reset; pointers define validity.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/seq_bit_serializer.sv
// Word-to-bit serializer feeding the sequence detector; FIFO-buffered, gap-free when fed.
// Define SEQ_SER_PARITY_EN to append an even-parity bit after each word.
module seq_bit_serializer
   import seq_pkg::*;
#(
   parameter int unsigned WIDTH     = DefWidth,
   parameter int unsigned DEPTH     = DefDepth,
   parameter bit          MSB_FIRST = 1'b1,
   parameter bit          IDLE_BIT  = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [WIDTH-1:0]        in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic                    bit_out,
   output logic                    bit_valid,
   output logic                    word_start,
   output logic                    word_last,
   output logic [$clog2(DEPTH):0]  fifo_count
);

   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [$clog2(DEPTH):0] Full = DEPTH[$clog2(DEPTH):0];

   ser_state_t       r_state;
   logic             r_init;
   logic [WIDTH-1:0] r_shift;
   logic [CntW-1:0]  r_cnt;
   logic             r_bit;
   logic             r_valid;
   logic             r_start;
   logic             r_last;
`ifdef SEQ_SER_PARITY_EN
   logic             r_par;
`endif

   logic [WIDTH-1:0] w_fifo_data;
   logic [WIDTH-1:0] w_load_shift;
   logic [WIDTH-1:0] w_run_shift;
   logic             w_first;
   logic             w_next;
   logic             w_push;
   logic             w_word_done;
   logic             w_load;

   // r_init holds in_ready low until the first edge after reset release.
   assign in_ready   = r_init && (fifo_count < Full);
   assign w_push     = in_valid && in_ready;
   assign bit_out    = r_bit;
   assign bit_valid  = r_valid;
   assign word_start = r_start;
   assign word_last  = r_last;

   assign w_first      = MSB_FIRST ? w_fifo_data[WIDTH-1] : w_fifo_data[0];
   assign w_next       = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
   assign w_load_shift = MSB_FIRST ? (w_fifo_data << 1) : (w_fifo_data >> 1);
   assign w_run_shift  = MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);

`ifdef SEQ_SER_PARITY_EN
   assign w_word_done = (r_state == StParity);
`else
   assign w_word_done = (r_state == StShift) && (r_cnt == '0);
`endif
   assign w_load = (fifo_count != '0) && ((r_state == StIdle) || w_word_done);

   seq_sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (in_data),
      .i_pop   (w_load),
      .o_data  (w_fifo_data),
      .o_count (fifo_count)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= StIdle;
         r_init  <= 1'b0;
         r_shift <= '0;
         r_cnt   <= '0;
         r_bit   <= IDLE_BIT;
         r_valid <= 1'b0;
         r_start <= 1'b0;
         r_last  <= 1'b0;
`ifdef SEQ_SER_PARITY_EN
         r_par   <= 1'b0;
`endif
      end else begin
         r_init <= 1'b1;
         if (w_load) begin
            // First bit goes out on the pop edge; the rest waits in r_shift.
            r_state <= StShift;
            r_shift <= w_load_shift;
            r_cnt   <= CntW'(WIDTH - 1);
            r_bit   <= w_first;
            r_valid <= 1'b1;
            r_start <= 1'b1;
`ifdef SEQ_SER_PARITY_EN
            r_last  <= 1'b0;
            r_par   <= ^w_fifo_data;
`else
            r_last  <= (WIDTH == 1);
`endif
         end else begin
            unique case (r_state)
               StShift: begin
                  if (r_cnt != '0) begin
                     r_shift <= w_run_shift;
                     r_cnt   <= r_cnt - 1'b1;
                     r_bit   <= w_next;
                     r_start <= 1'b0;
`ifdef SEQ_SER_PARITY_EN
                     r_last  <= 1'b0;
`else
                     r_last  <= (r_cnt == CntW'(1));
`endif
                  end else begin
`ifdef SEQ_SER_PARITY_EN
                     r_state <= StParity;
                     r_bit   <= r_par;
                     r_start <= 1'b0;
                     r_last  <= 1'b1;
`else
                     r_state <= StIdle;
                     r_bit   <= IDLE_BIT;
                     r_valid <= 1'b0;
                     r_start <= 1'b0;
                     r_last  <= 1'b0;
`endif
                  end
               end
               default: begin
                  r_state <= StIdle;
                  r_bit   <= IDLE_BIT;
                  r_valid <= 1'b0;
                  r_start <= 1'b0;
                  r_last  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/seq_bit_serializer.md
Name: seq_bit_serializer

Overview:
- Upstream feeder for the sequence detector.
- Accepts parallel words over a valid/ready handshake, buffers them in a small FIFO, and emits one bit per clock on bit_out. bit_out drives the detector's serial input `i`.
- Produces a gap-free bit stream when words arrive back-to-back. Inserts IDLE_BIT when no data is available.

Parameters:
- WIDTH, 8: bits per input word.
- DEPTH, 4: FIFO entries; power of 2, minimum 2.
- MSB_FIRST, 1: 1 = shift MSB first; 0 = LSB first.
- IDLE_BIT, 0: value driven on bit_out when not shifting.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- in_data  input  WIDTH  word to serialize.
- in_valid  input  1  in_data valid.
- in_ready  output  1  FIFO can accept a word this cycle.
- bit_out  output  1  serial bit to detector.
- bit_valid  output  1  bit_out carries payload (not idle fill).
- word_start  output  1  high with first bit of each word.
- word_last  output  1  high with final bit of each word (parity bit when enabled).
- fifo_count  output  $clog2(DEPTH)+1  words currently buffered (excludes word in shifter).

Behaviour:
- Reset (rst=0, asynchronous): FIFO emptied, state IDLE, bit_out=IDLE_BIT, bit_valid=0, word_start=0, word_last=0, fifo_count=0, in_ready=0 while asserted. in_ready=1 from first clk edge after release.
- Reset mid-word: the partial word and all buffered words are discarded. No completion is output.
- Handshake: transfer on a rising edge with in_valid & in_ready.
  - in_ready = (fifo_count < DEPTH), computed from registered count.
  - A push when full is refused even if a pop occurs that same edge.
  - in_data is ignored when in_ready=0.
- Simultaneous push and pop, not full: fifo_count is unchanged and both operations take effect.
- FSM states: IDLE, SHIFT (plus PARITY when option enabled).
  - IDLE: if fifo_count>0 at an edge, pop into shift register, bit counter=WIDTH-1, go to SHIFT. Otherwise stay; bit_out=IDLE_BIT, bit_valid=0.
  - SHIFT: each edge outputs the next bit (MSB or LSB per MSB_FIRST) and decrements the counter.
  - On the last data bit, with no parity: if fifo_count>0, pop the next word in the same edge and stay in SHIFT, so there is no idle gap. Otherwise return to IDLE.
- Outputs are registered.
- Latency: word accepted at edge t into an empty FIFO in IDLE gives its first bit during the cycle after edge t+1. That is two edges, with word_start=1.
- Throughput: one bit per clock sustained. A word of WIDTH bits is consumed every WIDTH cycles (WIDTH+1 with parity).
- fifo_count wraps never: range 0..DEPTH. Pointers are $clog2(DEPTH) bits, wrapping modulo DEPTH.

Optional Feature:
- Macro SEQ_SER_PARITY_EN.
- Defined: after the last data bit, FSM enters PARITY for one cycle.
  - Emits even parity (XOR of all WIDTH data bits) with bit_valid=1 and word_last=1.
  - The back-to-back pop moves to the PARITY cycle.
- Undefined: PARITY state and logic are absent. word_last accompanies the final data bit.

Decomposition:
- Package seq_pkg:
  - ser_state_t enum (IDLE, SHIFT, PARITY).
  - Default width/depth constants shared with the detector bench.
- Sub-module seq_sync_fifo:
  - Parameterized WIDTH/DEPTH.
  - push/pop/count, no data forwarding when empty.
  - Instantiated once.
- The FSM and shifter live in seq_bit_serializer.

Test Plan:
- Single word, MSB_FIRST=1: push 0xB4 at edge 0 → bit_out 1,0,1,1,0,1,0,0 on cycles after edges 1–8. bit_valid=1 throughout, word_start on the first bit, word_last on the eighth. Then IDLE_BIT with bit_valid=0.
- Back-to-back: push 0xFF then 0x00 on consecutive edges → 16 contiguous valid bits, eight 1s then eight 0s. No gap; word_start at bits 1 and 9.
- FIFO full: push 6 words on consecutive edges (in_valid held) → fifo_count reaches 4 and in_ready drops. Only words accepted while in_ready=1 appear serially, in order. in_ready reasserts the edge after a pop.
- LSB first (MSB_FIRST=0): push 0x01 → bit_out 1,0,0,0,0,0,0,0.
- Reset mid-word: assert rst=0 after 3 bits of 0xB4 with 2 words queued → immediately bit_valid=0, fifo_count=0, bit_out=IDLE_BIT. After release, no stale bits appear.
- Parity (SEQ_SER_PARITY_EN defined): 0xB4 → 9th bit 0; 0x07 → 9th bit 1. word_last is on the 9th bit; the next word starts on the cycle after it.
